// File: rtl/aes_cmd_pkg.sv
// Shared constants, FSM states and register-map helpers for the AES command-bus master.
package aes_cmd_pkg;

   localparam logic [7:0] OFF_START = 8'h00;
   localparam logic [7:0] OFF_STATE = 8'h01;
   localparam logic [7:0] OFF_ADDR  = 8'h02;
   localparam logic [7:0] OFF_LEN   = 8'h04;
   localparam logic [7:0] OFF_CTR   = 8'h10;
   localparam logic [7:0] OFF_KEY0  = 8'h20;

   localparam int         NUM_CFG_BYTES = 36;
   localparam logic [7:0] START_CMD     = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REGS,
      ST_WR_START,
      ST_POLL_RD,
      ST_POLL_WAIT
   } state_e;

   // Register offset for configuration byte idx (ADDR, LEN, CTR, KEY0, all little-endian).
   function automatic logic [7:0] cfg_offset(input logic [5:0] idx);
      if (idx < 6'd2)       return OFF_ADDR + {2'b00, idx};
      else if (idx < 6'd4)  return OFF_LEN  + {2'b00, idx - 6'd2};
      else if (idx < 6'd20) return OFF_CTR  + {2'b00, idx - 6'd4};
      else                  return OFF_KEY0 + {2'b00, idx - 6'd20};
   endfunction

endpackage

// File: rtl/aes_cmd_xfer.sv
// Single-transfer engine: registered stb/wr/addr/data held until ack, with ack timeout.
module aes_cmd_xfer #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        xfer_done,
   output logic        xfer_timeout,
   output logic        cmd_stb,
   output logic        cmd_wr,
   output logic [15:0] cmd_addr,
   output logic [7:0]  cmd_data_out,
   input  logic [7:0]  cmd_data_in,
   input  logic        cmd_ack
);

   logic [7:0] wait_cnt;

   assign rdata        = cmd_data_in;
   assign xfer_done    = cmd_stb && cmd_ack;
   // An ack in the limit cycle wins because the timeout is qualified by !cmd_ack.
   assign xfer_timeout = cmd_stb && !cmd_ack && (wait_cnt == 8'(ACK_TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_stb      <= 1'b0;
         cmd_wr       <= 1'b0;
         cmd_addr     <= '0;
         cmd_data_out <= '0;
         wait_cnt     <= '0;
      end else if (!cmd_stb) begin
         // Low stb after an ack guarantees the single idle cycle between transfers.
         if (req) begin
            cmd_stb      <= 1'b1;
            cmd_wr       <= wr;
            cmd_addr     <= addr;
            cmd_data_out <= wdata;
            wait_cnt     <= '0;
         end
      end else if (xfer_done || xfer_timeout) begin
         cmd_stb <= 1'b0;
      end else begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/aes_cmd_master.sv
// Programs the AES register file from one job request, starts the engine and polls it to idle.
module aes_cmd_master
   import aes_cmd_pkg::*;
#(
   parameter logic [15:0] AES_BASE    = 16'hff00,
   parameter int          ACK_TIMEOUT = 255,
   parameter int          POLL_GAP    = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [15:0]  job_addr,
   input  logic [15:0]  job_len,
   input  logic [127:0] job_ctr,
   input  logic [127:0] job_key,
   output logic         done,
   output logic         err,
   output logic         busy,
   output logic         cmd_stb,
   output logic         cmd_wr,
   output logic [15:0]  cmd_addr,
   output logic [7:0]   cmd_data_out,
   input  logic [7:0]   cmd_data_in,
   input  logic         cmd_ack
);

   state_e                       state;
   logic [5:0]                   idx;
   logic [7:0]                   gap_cnt;
   logic [NUM_CFG_BYTES*8-1:0]   cfg_q;

   logic        x_req;
   logic        x_wr;
   logic [15:0] x_addr;
   logic [7:0]  x_wdata;
   logic [7:0]  x_rdata;
   logic        x_done;
   logic        x_timeout;

   // NOTE: the job payload is pure data qualified by the FSM, so it is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && job_valid) begin
         cfg_q <= {job_key, job_ctr, job_len, job_addr};
      end
   end

   // In IDLE the first byte comes straight from the job inputs so stb rises right after accept.
   // NOTE: every always_comb output gets a default first, which rules out inferred latches.
   always_comb begin
      x_req   = 1'b0;
      x_wr    = 1'b1;
      x_addr  = AES_BASE + {8'h00, OFF_START};
      x_wdata = 8'h00;
      case (state)
         ST_IDLE: begin
            x_req   = job_valid;
            x_addr  = AES_BASE + {8'h00, OFF_ADDR};
            x_wdata = job_addr[7:0];
         end
         ST_WR_REGS: begin
            x_req   = 1'b1;
            x_addr  = AES_BASE + {8'h00, cfg_offset(idx)};
            x_wdata = cfg_q[{idx, 3'b000} +: 8];
         end
         ST_WR_START: begin
            x_req   = 1'b1;
            x_wdata = START_CMD;
         end
         ST_POLL_RD: begin
            x_req  = 1'b1;
            x_wr   = 1'b0;
            x_addr = AES_BASE + {8'h00, OFF_STATE};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         gap_cnt   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         job_ready <= 1'b1;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (job_valid) begin
                  state     <= ST_WR_REGS;
                  idx       <= '0;
                  busy      <= 1'b1;
                  job_ready <= 1'b0;
               end
            end
            ST_WR_REGS: begin
               if (x_done) begin
                  if (idx == 6'(NUM_CFG_BYTES - 1)) state <= ST_WR_START;
                  else                              idx   <= idx + 6'd1;
               end
            end
            ST_WR_START: begin
               if (x_done) state <= ST_POLL_RD;
            end
            ST_POLL_RD: begin
               if (x_done) begin
                  if (x_rdata == 8'h00) begin
                     state     <= ST_IDLE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     job_ready <= 1'b1;
                  end else if (POLL_GAP > 1) begin
                     state   <= ST_POLL_WAIT;
                     gap_cnt <= '0;
                  end
               end
            end
            ST_POLL_WAIT: begin
               // Leaving one cycle early lets the normal post-ack gap complete the POLL_GAP idle cycles.
               if (gap_cnt == 8'(POLL_GAP - 2)) state   <= ST_POLL_RD;
               else                             gap_cnt <= gap_cnt + 8'd1;
            end
            default: state <= ST_IDLE;
         endcase
         if (x_timeout) begin
            state     <= ST_IDLE;
            done      <= 1'b1;
            err       <= 1'b1;
            busy      <= 1'b0;
            job_ready <= 1'b1;
         end
      end
   end

   aes_cmd_xfer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_xfer (
      .clk          (clk),
      .rst          (rst),
      .req          (x_req),
      .wr           (x_wr),
      .addr         (x_addr),
      .wdata        (x_wdata),
      .rdata        (x_rdata),
      .xfer_done    (x_done),
      .xfer_timeout (x_timeout),
      .cmd_stb      (cmd_stb),
      .cmd_wr       (cmd_wr),
      .cmd_addr     (cmd_addr),
      .cmd_data_out (cmd_data_out),
      .cmd_data_in  (cmd_data_in),
      .cmd_ack      (cmd_ack)
   );

endmodule

// File: tb/tb_aes_cmd_master.sv
// Bench for aes_cmd_master: scripted responder, transaction log and a byte-sequence reference model.
module tb_aes_cmd_master;

   localparam logic [15:0] BASE = 16'hff00;
   localparam int          TMO  = 8;
   localparam int          GAP  = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         job_valid = 1'b0;
   logic         job_ready;
   logic [15:0]  job_addr = '0;
   logic [15:0]  job_len = '0;
   logic [127:0] job_ctr = '0;
   logic [127:0] job_key = '0;
   logic         done, err, busy;
   logic         cmd_stb, cmd_wr;
   logic [15:0]  cmd_addr;
   logic [7:0]   cmd_data_out;
   logic [7:0]   cmd_data_in = 8'h00;
   logic         cmd_ack = 1'b0;

   aes_cmd_master #(
      .AES_BASE    (BASE),
      .ACK_TIMEOUT (TMO),
      .POLL_GAP    (GAP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .job_valid    (job_valid),
      .job_ready    (job_ready),
      .job_addr     (job_addr),
      .job_len      (job_len),
      .job_ctr      (job_ctr),
      .job_key      (job_key),
      .done         (done),
      .err          (err),
      .busy         (busy),
      .cmd_stb      (cmd_stb),
      .cmd_wr       (cmd_wr),
      .cmd_addr     (cmd_addr),
      .cmd_data_out (cmd_data_out),
      .cmd_data_in  (cmd_data_in),
      .cmd_ack      (cmd_ack)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  data;
      int          start;
      int          ackc;
   } xfer_t;

   xfer_t      log_q[$];
   logic [7:0] poll_q[$];
   int         lat_mode  = 1;
   int         hang_at   = -1;
   bit         spur_en   = 1'b0;
   int         xfer_no   = 0;
   int         stab_bad  = 0;
   int         last_hold = 0;
   bit         in_x = 1'b0;
   int         xc = 0, xlat = 0, st0 = 0;
   logic [15:0] a0;
   logic [7:0]  d0;
   logic        w0;

   // Responder: drives ack/data on the falling edge, logs each acked transfer.
   always @(negedge clk) begin
      if (cmd_stb) begin
         if (!in_x) begin
            in_x = 1'b1;
            xc   = 0;
            xlat = (lat_mode < 0) ? int'($urandom_range(0, 5)) : lat_mode;
            a0   = cmd_addr;
            d0   = cmd_data_out;
            w0   = cmd_wr;
            st0  = cyc;
         end else begin
            xc = xc + 1;
            if (cmd_addr !== a0 || cmd_data_out !== d0 || cmd_wr !== w0) stab_bad = stab_bad + 1;
         end
         if (xfer_no != hang_at && xc == xlat) begin
            cmd_ack = 1'b1;
            if (!w0 && poll_q.size() > 0) cmd_data_in = poll_q.pop_front();
            else                          cmd_data_in = 8'h00;
            log_q.push_back('{w0, a0, d0, st0, cyc});
            xfer_no = xfer_no + 1;
         end else begin
            cmd_ack     = 1'b0;
            cmd_data_in = 8'h5a;
         end
      end else begin
         if (in_x) begin
            last_hold = xc + 1;
            in_x      = 1'b0;
         end
         cmd_ack     = spur_en;
         cmd_data_in = 8'h00;
      end
   end

   int done_cnt = 0, err_cnt = 0, done_cyc = 0;
   logic busy_at_done = 1'b0, err_at_done = 1'b0;

   always @(negedge clk) begin
      if (done) begin
         done_cnt     = done_cnt + 1;
         done_cyc     = cyc;
         busy_at_done = busy;
         err_at_done  = err;
      end
      if (err) err_cnt = err_cnt + 1;
   end

   // Reference model: the 37 expected writes derived from the job fields and register map.
   function automatic int seq_errors(input logic [15:0] a, input logic [15:0] l,
                                     input logic [127:0] c, input logic [127:0] k, input int n_exp);
      logic [15:0] ea[$];
      logic [7:0]  ed[$];
      int errs = 0;
      for (int i = 0; i < 2; i++)  begin ea.push_back(BASE + 16'h02 + 16'(i)); ed.push_back(a[8*i +: 8]); end
      for (int i = 0; i < 2; i++)  begin ea.push_back(BASE + 16'h04 + 16'(i)); ed.push_back(l[8*i +: 8]); end
      for (int i = 0; i < 16; i++) begin ea.push_back(BASE + 16'h10 + 16'(i)); ed.push_back(c[8*i +: 8]); end
      for (int i = 0; i < 16; i++) begin ea.push_back(BASE + 16'h20 + 16'(i)); ed.push_back(k[8*i +: 8]); end
      ea.push_back(BASE);
      ed.push_back(8'h01);
      for (int i = 0; i < n_exp; i++) begin
         if (i >= log_q.size()) errs++;
         else if (log_q[i].wr !== 1'b1 || log_q[i].addr !== ea[i] || log_q[i].data !== ed[i]) errs++;
      end
      return errs;
   endfunction

   function automatic int read_errors(input int first, input int n);
      int errs = 0;
      if (log_q.size() != first + n) errs++;
      for (int i = first; i < first + n && i < log_q.size(); i++)
         if (log_q[i].wr !== 1'b0 || log_q[i].addr !== BASE + 16'h01) errs++;
      return errs;
   endfunction

   function automatic int gap_errors(input int from, input int to, input int want);
      int errs = 0;
      for (int k = from; k <= to && k < log_q.size(); k++)
         if (log_q[k].start - log_q[k-1].ackc - 1 != want) errs++;
      return errs;
   endfunction

   task automatic submit(input logic [15:0] a, input logic [15:0] l,
                         input logic [127:0] c, input logic [127:0] k, output int acc);
      @(negedge clk);
      total++;
      if (job_ready !== 1'b1) begin $display("FAIL submit_ready: job_ready=%b want 1", job_ready); bad++; end
      log_q.delete();
      xfer_no   = 0;
      stab_bad  = 0;
      job_valid = 1'b1;
      job_addr  = a;
      job_len   = l;
      job_ctr   = c;
      job_key   = k;
      @(negedge clk);
      job_valid = 1'b0;
      acc       = cyc;
   endtask

   task automatic wait_done(input int prev, input int budget, input string tag);
      int n = 0;
      while (done_cnt == prev && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (done_cnt == prev) begin $display("FAIL %s_wait_done: no done within %0d cycles", tag, budget); bad++; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({cmd_stb, cmd_wr, cmd_addr, cmd_data_out, done, err, busy, job_ready} !== {1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL reset_values: stb=%b wr=%b addr=%h data=%h done=%b err=%b busy=%b ready=%b",
                  cmd_stb, cmd_wr, cmd_addr, cmd_data_out, done, err, busy, job_ready);
         bad++;
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (cmd_stb !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1) begin
         $display("FAIL idle_after_reset: stb=%b busy=%b ready=%b want 0 0 1", cmd_stb, busy, job_ready);
         bad++;
      end
   endtask

   task automatic test_fixed_job();
      logic [127:0] c, k;
      int acc, d0c, e0c, n;
      for (int i = 0; i < 16; i++) begin
         c[8*i +: 8] = 8'(i);
         k[8*i +: 8] = 8'(8'hf0 + i);
      end
      lat_mode = 1;
      poll_q   = '{8'h01, 8'h01, 8'h00};
      d0c = done_cnt;
      e0c = err_cnt;
      submit(16'h1234, 16'h0020, c, k, acc);
      wait_done(d0c, 600, "fixed");
      repeat (3) @(negedge clk);
      n = seq_errors(16'h1234, 16'h0020, c, k, 37);
      total++; if (n != 0) begin $display("FAIL fixed_writes: %0d bad entries, want 0", n); bad++; end
      total++; if (log_q[0].start != acc) begin $display("FAIL fixed_first_stb: cycle %0d want %0d", log_q[0].start, acc); bad++; end
      if (log_q.size() >= 38) begin
         total++;
         if (log_q[37].start != acc + 111) begin $display("FAIL fixed_write_time: first read at %0d want %0d", log_q[37].start, acc + 111); bad++; end
      end
      n = read_errors(37, 3);
      total++; if (n != 0) begin $display("FAIL fixed_reads: %0d bad, log size %0d want 40", n, log_q.size()); bad++; end
      n = gap_errors(1, 37, 1);
      total++; if (n != 0) begin $display("FAIL fixed_write_gaps: %0d gaps not 1", n); bad++; end
      n = gap_errors(38, 39, GAP);
      total++; if (n != 0) begin $display("FAIL fixed_poll_gaps: %0d gaps not %0d", n, GAP); bad++; end
      total++; if (done_cnt != d0c + 1) begin $display("FAIL fixed_done_once: pulses=%0d want 1", done_cnt - d0c); bad++; end
      total++; if (err_cnt != e0c) begin $display("FAIL fixed_err: err pulses=%0d want 0", err_cnt - e0c); bad++; end
      if (log_q.size() >= 40) begin
         total++;
         if (done_cyc != log_q[39].ackc + 1) begin $display("FAIL fixed_done_time: %0d want %0d", done_cyc, log_q[39].ackc + 1); bad++; end
      end
      total++; if (busy_at_done !== 1'b0) begin $display("FAIL fixed_busy_at_done: busy=%b want 0", busy_at_done); bad++; end
   endtask

   task automatic test_timeout();
      logic [15:0] a, l;
      logic [127:0] c, k;
      int acc, d0c;
      a = 16'($urandom()); l = 16'($urandom());
      c = {$urandom(), $urandom(), $urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      lat_mode = 1;
      hang_at  = 4;
      d0c = done_cnt;
      submit(a, l, c, k, acc);
      wait_done(d0c, 300, "timeout");
      repeat (2) @(negedge clk);
      hang_at = -1;
      total++; if (log_q.size() != 4 || seq_errors(a, l, c, k, 4) != 0) begin $display("FAIL tmo_writes: log size %0d want 4", log_q.size()); bad++; end
      total++; if (last_hold != TMO) begin $display("FAIL tmo_stb_hold: %0d cycles want %0d", last_hold, TMO); bad++; end
      total++; if (err_at_done !== 1'b1) begin $display("FAIL tmo_err_with_done: err=%b want 1", err_at_done); bad++; end
      if (log_q.size() >= 4) begin
         total++;
         if (done_cyc != log_q[3].ackc + 2 + TMO) begin $display("FAIL tmo_done_time: %0d want %0d", done_cyc, log_q[3].ackc + 2 + TMO); bad++; end
      end
      total++; if (job_ready !== 1'b1 || busy !== 1'b0 || cmd_stb !== 1'b0) begin
         $display("FAIL tmo_idle: ready=%b busy=%b stb=%b want 1 0 0", job_ready, busy, cmd_stb); bad++; end
   endtask

   task automatic test_random_lat();
      for (int j = 0; j < 3; j++) begin
         logic [15:0] a, l;
         logic [127:0] c, k;
         int acc, d0c, e0c, n;
         a = 16'($urandom()); l = 16'($urandom());
         c = {$urandom(), $urandom(), $urandom(), $urandom()};
         k = {$urandom(), $urandom(), $urandom(), $urandom()};
         lat_mode = -1;
         poll_q   = '{8'(1 + $urandom_range(0, 254)), 8'h00};
         d0c = done_cnt;
         e0c = err_cnt;
         submit(a, l, c, k, acc);
         wait_done(d0c, 1000, "rand");
         repeat (2) @(negedge clk);
         n = seq_errors(a, l, c, k, 37);
         total++; if (n != 0) begin $display("FAIL rand_writes[%0d]: %0d bad entries", j, n); bad++; end
         total++; if (stab_bad != 0) begin $display("FAIL rand_stable[%0d]: %0d changes before ack", j, stab_bad); bad++; end
         n = gap_errors(1, 37, 1) + gap_errors(38, 38, GAP) + read_errors(37, 2);
         total++; if (n != 0) begin $display("FAIL rand_gaps_reads[%0d]: %0d errors", j, n); bad++; end
         total++; if (err_cnt != e0c || done_cnt != d0c + 1) begin
            $display("FAIL rand_done[%0d]: done=%0d err=%0d want 1 0", j, done_cnt - d0c, err_cnt - e0c); bad++; end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] a, l;
      logic [127:0] c, k;
      int acc, d0c, e0c, n, cnt;
      a = 16'($urandom()); l = 16'($urandom());
      c = {$urandom(), $urandom(), $urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      lat_mode = 1;
      poll_q.delete();
      d0c = done_cnt;
      e0c = err_cnt;
      submit(a, l, c, k, acc);
      cnt = 0;
      while (!(cmd_stb && cmd_addr == BASE + 16'h1a) && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      total++; if (cnt >= 200) begin $display("FAIL rstmid_reach_ctr10: not reached, addr=%h", cmd_addr); bad++; end
      rst = 1'b1;
      @(negedge clk);
      total++; if (cmd_stb !== 1'b0 || busy !== 1'b0) begin $display("FAIL rstmid_drop: stb=%b busy=%b want 0 0", cmd_stb, busy); bad++; end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (done_cnt != d0c || err_cnt != e0c || job_ready !== 1'b1) begin
         $display("FAIL rstmid_no_done: done=%0d err=%0d ready=%b want 0 0 1", done_cnt - d0c, err_cnt - e0c, job_ready); bad++; end
      a = 16'($urandom());
      poll_q = '{8'h00};
      submit(a, l, c, k, acc);
      wait_done(d0c, 600, "rstmid");
      repeat (2) @(negedge clk);
      n = seq_errors(a, l, c, k, 37) + read_errors(37, 1);
      total++; if (n != 0 || log_q[0].addr !== BASE + 16'h02) begin
         $display("FAIL rstmid_restart: %0d errors, first addr=%h want ff02", n, log_q[0].addr); bad++; end
   endtask

   task automatic test_spurious_busy();
      logic [15:0] a, l;
      logic [127:0] c, k;
      int acc, d0c, e0c, n, cnt;
      a = 16'($urandom()); l = 16'($urandom());
      c = {$urandom(), $urandom(), $urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      lat_mode = 1;
      poll_q   = '{8'h03, 8'h00};
      d0c = done_cnt;
      e0c = err_cnt;
      submit(a, l, c, k, acc);
      repeat (20) @(negedge clk);
      job_valid = 1'b1;
      job_addr  = ~a;
      job_key   = ~k;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (job_ready !== 1'b0) begin $display("FAIL busy_not_ready[%0d]: job_ready=%b want 0", i, job_ready); bad++; end
      end
      job_valid = 1'b0;
      cnt = 0;
      while (log_q.size() < 38 && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      spur_en = 1'b1;
      wait_done(d0c, 400, "spur");
      spur_en = 1'b0;
      repeat (4) @(negedge clk);
      n = seq_errors(a, l, c, k, 37) + read_errors(37, 2);
      total++; if (n != 0) begin $display("FAIL spur_sequence: %0d errors, log size %0d want 39", n, log_q.size()); bad++; end
      n = gap_errors(38, 38, GAP);
      total++; if (n != 0) begin $display("FAIL spur_poll_gap: %0d gaps not %0d", n, GAP); bad++; end
      total++; if (done_cnt != d0c + 1 || err_cnt != e0c || cmd_stb !== 1'b0) begin
         $display("FAIL spur_single_job: done=%0d err=%0d stb=%b want 1 0 0", done_cnt - d0c, err_cnt - e0c, cmd_stb); bad++; end
   endtask

   initial begin
      test_reset();
      test_fixed_job();
      test_timeout();
      test_random_lat();
      test_reset_mid();
      test_spurious_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/aes_cmd_master.md
# aes_cmd_master

Bus initiator for the AES accelerator's 8-bit command bus, which carries stb, wr, addr, data and ack. Takes one encryption job as a parallel request and programs the AES register file byte by byte. It then writes the start register, polls the state register until the engine returns to idle, and reports completion. In the AES+XRAM testbench top it stands in for the 8051 core (or the C-simulation command driver).

## Interface
Parameters:
- AES_BASE, 16'hff00, base address of the AES register map.
- ACK_TIMEOUT, 255, maximum cycles stb may wait for ack before aborting (8-bit counter).
- POLL_GAP, 4, idle cycles between consecutive state-register reads.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  job request.
- job_ready  out  1  high only in IDLE.
- job_addr  in  16  XRAM start address.
- job_len  in  16  byte length.
- job_ctr  in  128  initial counter.
- job_key  in  128  key0.
- done  out  1  one-cycle pulse at job end.
- err  out  1  one-cycle pulse, coincident with done, on ack timeout.
- busy  out  1  high when not in IDLE.
- cmd_stb  out  1  transfer strobe.
- cmd_wr  out  1  1 = write, 0 = read.
- cmd_addr  out  16  register address.
- cmd_data_out  out  8  write data.
- cmd_data_in  in  8  read data, valid in the ack cycle.
- cmd_ack  in  1  responder acknowledge.

## Operation
Register map offsets from AES_BASE:
- START +0x00 (write 0x01)
- STATE +0x01 (read; 0 = idle)
- ADDR +0x02..0x03
- LEN +0x04..0x05
- CTR +0x10..0x1f
- KEY0 +0x20..0x2f

All multi-byte fields are little-endian: the lowest address carries bits [7:0].

- Job capture: on job_valid && job_ready, all job fields are latched. Inputs are ignored thereafter.
- Write order, fixed, 37 writes: ADDR lo, ADDR hi, LEN lo, LEN hi, CTR bytes 0..15, KEY0 bytes 0..15, then START=0x01.
- The byte index is a 6-bit counter, 0..35. Index 36 is START.

States:
- IDLE -> WR_REGS on job accept.
- WR_REGS -> WR_START after the ack of index 35.
- WR_START -> POLL_RD on ack.
- POLL_RD -> IDLE on an ack with cmd_data_in == 0: done pulses in the cycle after that ack.
- POLL_RD -> POLL_WAIT on an ack with cmd_data_in != 0.
- POLL_WAIT -> POLL_RD after POLL_GAP cycles.
- Any transfer state -> IDLE on timeout, with done and err both pulsed. The job is not retried.

Polling has no iteration limit; only ack timeout aborts.

## Timing
- Reset values: cmd_stb=0, cmd_wr=0, cmd_addr=0, cmd_data_out=0, done=0, err=0, busy=0, job_ready=1. The state register resets to IDLE.
- Reset mid-transfer drops cmd_stb the cycle after rst is sampled, with no done/err. rst is shared with the AES engine.
- First cmd_stb is asserted the cycle after job accept.
- Handshake: cmd_stb, cmd_wr, cmd_addr and cmd_data_out are registered and held stable until cmd_ack is sampled high.
- cmd_ack is sampled only while cmd_stb=1. It may arrive in the same cycle as stb.
- After an ack cycle, cmd_stb is low for exactly one cycle before the next transfer.
- Timeout counter:
  - Clears at each stb assertion and increments while stb=1 && !ack.
  - When it reaches ACK_TIMEOUT without ack, stb drops the next cycle.
  - An ack arriving in the same cycle as the limit wins.
- cmd_ack while cmd_stb=0 is ignored.
- With a responder acking one cycle after stb, each transfer takes 3 cycles, so 37 writes take 111 cycles.

## Structure
- Package aes_cmd_pkg holds:
  - register offsets (OFF_START, OFF_STATE, OFF_ADDR, OFF_LEN, OFF_CTR, OFF_KEY0);
  - the state enum;
  - NUM_CFG_BYTES = 36.
- Sub-module aes_cmd_xfer is a single-transfer engine:
  - inputs: req, wr, addr, wdata;
  - outputs: rdata, xfer_done, xfer_timeout;
  - owns the stb/ack/gap/timeout logic.
- The top-level FSM handles byte sequencing and polling.

## Test plan
- Job addr=0x1234, len=0x0020, ctr=0x00..0f, key=0xf0..ff against a responder acking in 1 cycle -> write sequence:
  - ff02=34, ff03=12, ff04=20, ff05=00;
  - ff10..ff1f = 00..0f;
  - ff20..ff2f = f0..ff;
  - ff00=01;
  - first stb one cycle after accept; 111 cycles of writes.
- Responder STATE returns 1, 1, 0 -> three reads at ff01, each pair separated by POLL_GAP=4 idle cycles; done pulses once, err=0; busy falls with done.
- Responder never acks the 5th write, ACK_TIMEOUT=8 -> stb held 8 cycles, then dropped; done and err pulse together; back to IDLE with job_ready=1.
- Ack latencies randomized 0..5 cycles -> addr/data stable until ack; exactly one idle cycle between transfers; same byte sequence as the first scenario.
- rst asserted during CTR write index 10 -> stb=0 and busy=0 the next cycle, no done; a new job then restarts from ADDR lo.
- Spurious ack with stb=0 during POLL_WAIT -> no state change; job_valid while busy -> not accepted.
